// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin arbiter sharing one serial frame transmitter
// between NUM_MASTERS requesters, with split-transaction masking and resume
// priority. Optional compile-time feature: ARB_WATCHDOG_EN (WAIT_DONE watchdog).
// bus_pkg carries the frame type shared with the serializer.

package bus_pkg;
  typedef enum logic [1:0] {
    CMD_READ           = 2'd0,
    CMD_WRITE          = 2'd1,
    CMD_SPLIT_START    = 2'd2,
    CMD_SPLIT_CONTINUE = 2'd3
  } cmd_t;

  typedef struct packed {
    cmd_t        cmd;
    logic [13:0] addr;
    logic [7:0]  data;
  } serial_frame_t;
endpackage

module serial_tx_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = $clog2(NUM_MASTERS),
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic          [NUM_MASTERS-1:0]     req_i,
  input  serial_frame_t [NUM_MASTERS-1:0]     frame_i,
  output logic          [NUM_MASTERS-1:0]     gnt_o,
  output logic          [NUM_MASTERS-1:0]     ack_o,
  output logic                                ser_valid_o,
  output serial_frame_t                       ser_frame_o,
  input  logic                                ser_ready_i,
  input  logic                                ser_done_i,
  input  logic                                split_resume_i,
  input  logic          [IDX_W-1:0]           split_id_i,
  output logic          [NUM_MASTERS-1:0]     split_pending_o,
  output logic                                busy_o,
  output logic                                timeout_o
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

  state_t                  state_reg, state_next;
  logic [NUM_MASTERS-1:0]  gnt_reg;
  logic [NUM_MASTERS-1:0]  ack_reg;
  serial_frame_t           frame_reg;
  logic [IDX_W-1:0]        ptr_reg;
  logic [NUM_MASTERS-1:0]  pending_reg, pending_next;
  logic [NUM_MASTERS-1:0]  resume_reg, resume_next;

  logic [NUM_MASTERS-1:0]  eligible;
  logic [NUM_MASTERS-1:0]  resume_hit;
  logic                    win_found;
  logic [IDX_W-1:0]        win_idx;
  logic [NUM_MASTERS-1:0]  win_onehot;
  logic                    wdog_expire;

  // Map any non-negative integer onto a master index, wrapping modulo NUM_MASTERS.
  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_MASTERS);
  endfunction

  // Winner selection: resumed split masters first (lowest index), else round robin from the pointer.
  always_comb begin
    eligible   = req_i & ~pending_reg;
    resume_hit = eligible & resume_reg;
    win_found  = 1'b0;
    win_idx    = '0;
    if (|resume_hit) begin
      win_found = 1'b1;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (resume_hit[i]) win_idx = IDX_W'(i);
      end
    end else begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (!win_found && eligible[wrap_idx(int'(ptr_reg) + k)]) begin
          win_found = 1'b1;
          win_idx   = wrap_idx(int'(ptr_reg) + k);
        end
      end
    end
    win_onehot = NUM_MASTERS'(1) << win_idx;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; a watchdog expiry only ever fires without ser_done_i.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (win_found) state_next = SEND;
      SEND:      if (ser_ready_i) state_next = WAIT_DONE;
      WAIT_DONE: if (ser_done_i || wdog_expire) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state register and datapath registers.
  always_comb begin
    ser_valid_o     = (state_reg == SEND);
    busy_o          = (state_reg != IDLE);
    gnt_o           = gnt_reg;
    ack_o           = ack_reg;
    ser_frame_o     = frame_reg;
    split_pending_o = pending_reg;
  end

  // Split bookkeeping: resume only acts on a bit that is already pending, so a
  // same-cycle SPLIT_START handshake for that id leaves it pending.
  always_comb begin
    pending_next = pending_reg;
    resume_next  = resume_reg;
    if (split_resume_i && (int'(split_id_i) < NUM_MASTERS) && pending_reg[split_id_i]) begin
      pending_next[split_id_i] = 1'b0;
      resume_next[split_id_i]  = 1'b1;
    end
    if (state_reg == IDLE && win_found) begin
      resume_next[win_idx] = 1'b0;
    end
    if (state_reg == SEND && ser_ready_i && frame_reg.cmd == CMD_SPLIT_START) begin
      pending_next = pending_next | gnt_reg;
    end
    if (wdog_expire && frame_reg.cmd == CMD_SPLIT_START) begin
      pending_next = pending_next & ~gnt_reg;
    end
  end

  // Grant, frame latch, pointer, ack pulse and split flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_reg     <= '0;
      ack_reg     <= '0;
      frame_reg   <= '0;
      ptr_reg     <= '0;
      pending_reg <= '0;
      resume_reg  <= '0;
    end else begin
      ack_reg     <= '0;
      pending_reg <= pending_next;
      resume_reg  <= resume_next;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            gnt_reg   <= win_onehot;
            frame_reg <= frame_i[win_idx];
            ptr_reg   <= wrap_idx(int'(win_idx) + 1);
          end
        end
        WAIT_DONE: begin
          if (ser_done_i) begin
            ack_reg <= gnt_reg;
            gnt_reg <= '0;
          end else if (wdog_expire) begin
            gnt_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;

  logic [WDOG_W-1:0] wdog_cnt_reg;
  logic              timeout_reg;

  // Counts cycles spent in WAIT_DONE; zero on the entry cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_reg != WAIT_DONE) wdog_cnt_reg <= '0;
    else                                 wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
  end

  assign wdog_expire = (state_reg == WAIT_DONE) && !ser_done_i &&
                       (wdog_cnt_reg == WDOG_W'(WDOG_CYCLES - 1));

  // One-cycle abort pulse following the expiry cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) timeout_reg <= 1'b0;
    else       timeout_reg <= wdog_expire;
  end

  assign timeout_o = timeout_reg;
`else
  assign wdog_expire = 1'b0;
  // Constant low; WDOG_CYCLES only matters when the watchdog is built in.
  assign timeout_o   = (WDOG_CYCLES < 0);
`endif

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter (4 masters, default build).
module tb_serial_tx_arbiter;
  import bus_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           req;
  serial_frame_t [3:0]  frame;
  logic [3:0]           gnt, ack, pending;
  logic                 ser_valid, ser_ready, ser_done;
  serial_frame_t        ser_frame;
  logic                 split_resume;
  logic [1:0]           split_id;
  logic                 busy, timeout;

  int tests  = 0;
  int failed = 0;

  serial_tx_arbiter #(.NUM_MASTERS(4), .WDOG_CYCLES(16)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_i           (req),
    .frame_i         (frame),
    .gnt_o           (gnt),
    .ack_o           (ack),
    .ser_valid_o     (ser_valid),
    .ser_frame_o     (ser_frame),
    .ser_ready_i     (ser_ready),
    .ser_done_i      (ser_done),
    .split_resume_i  (split_resume),
    .split_id_i      (split_id),
    .split_pending_o (pending),
    .busy_o          (busy),
    .timeout_o       (timeout)
  );

  always #5 clk = ~clk;

  function automatic serial_frame_t mk(input cmd_t c, input logic [13:0] a, input logic [7:0] d);
    serial_frame_t f;
    f.cmd  = c;
    f.addr = a;
    f.data = d;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next edge grants: check grant, valid and latched data.
  task automatic do_grant(input string tag, input logic [3:0] eg, input logic [7:0] ed);
    tick();
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".valid"}, 32'(ser_valid), 32'd1);
    chk({tag, ".data"}, 32'(ser_frame.data), 32'(ed));
    $display("[TB] %s grant=%b data=%h", tag, gnt, ser_frame.data);
  endtask

  // Handshake, one done pulse, then check the ack cycle.
  task automatic do_finish(input string tag, input logic [3:0] ea);
    ser_ready = 1'b1;
    tick();
    chk({tag, ".valid_low"}, 32'(ser_valid), 32'd0);
    ser_done = 1'b1;
    tick();
    ser_done = 1'b0;
    chk({tag, ".ack"}, 32'(ack), 32'(ea));
    chk({tag, ".gnt_clr"}, 32'(gnt), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; req = '0; frame = '0; ser_ready = 1'b0; ser_done = 1'b0;
    split_resume = 1'b0; split_id = '0;

    // Reset state
    tick(); tick();
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.ack", 32'(ack), 32'd0);
    chk("rst.valid", 32'(ser_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.pending", 32'(pending), 32'd0);
    chk("rst.frame", 32'(ser_frame), 32'd0);
    chk("rst.timeout", 32'(timeout), 32'd0);
    rst = 1'b0;

    // Single request, done five cycles after handshake
    req = 4'b0001; frame[0] = mk(CMD_WRITE, 14'h1234, 8'hAB); ser_ready = 1'b1;
    do_grant("single", 4'b0001, 8'hAB);
    chk("single.frame", 32'(ser_frame), 32'(mk(CMD_WRITE, 14'h1234, 8'hAB)));
    req = 4'b0000;
    tick();
    chk("single.valid_low", 32'(ser_valid), 32'd0);
    repeat (4) tick();
    chk("single.no_ack", 32'(ack), 32'd0);
    chk("single.busy_wait", 32'(busy), 32'd1);
    ser_done = 1'b1;
    tick();
    ser_done = 1'b0;
    chk("single.ack", 32'(ack), 32'b0001);
    chk("single.busy_end", 32'(busy), 32'd0);
    tick();
    chk("single.ack_pulse", 32'(ack), 32'd0);

    // Round robin from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) frame[i] = mk(CMD_WRITE, 14'(14'h100 + i), 8'(8'h10 + i));
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      do_grant("rr", 4'(1 << order[r]), 8'(8'h10 + order[r]));
      do_finish("rr", 4'(1 << order[r]));
    end

    // Backpressure: pointer at 1 after the wrap
    req = 4'b0010; ser_ready = 1'b0; frame[1] = mk(CMD_READ, 14'h2AAA, 8'h5C);
    do_grant("bp", 4'b0010, 8'h5C);
    req = 4'b0000;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) frame[1] = mk(CMD_WRITE, 14'h0001, 8'h99);
      tick();
      chk("bp.valid", 32'(ser_valid), 32'd1);
      chk("bp.frame", 32'(ser_frame), 32'(mk(CMD_READ, 14'h2AAA, 8'h5C)));
    end
    do_finish("bp", 4'b0010);

    // Split flow: master 2 starts a split, is masked, then resumed with priority
    req = 4'b0100; frame[2] = mk(CMD_SPLIT_START, 14'h0500, 8'h00);
    do_grant("split_start", 4'b0100, 8'h00);
    req = 4'b0000;
    do_finish("split_start", 4'b0100);
    chk("split.pending", 32'(pending), 32'b0100);
    req = 4'b0111;
    frame[0] = mk(CMD_WRITE, 14'h0010, 8'h20);
    frame[1] = mk(CMD_WRITE, 14'h0011, 8'h21);
    do_grant("masked0", 4'b0001, 8'h20);
    do_finish("masked0", 4'b0001);
    do_grant("masked1", 4'b0010, 8'h21);
    do_finish("masked1", 4'b0010);
    do_grant("masked0b", 4'b0001, 8'h20);
    ser_ready = 1'b1;
    tick();
    split_resume = 1'b1; split_id = 2'd2;
    frame[2] = mk(CMD_SPLIT_CONTINUE, 14'h0500, 8'h42);
    tick();
    split_resume = 1'b0;
    chk("resume.pending", 32'(pending), 32'd0);
    ser_done = 1'b1;
    tick();
    ser_done = 1'b0;
    chk("masked0b.ack", 32'(ack), 32'b0001);
    do_grant("resumed", 4'b0100, 8'h42);
    chk("resumed.cmd", 32'(ser_frame.cmd), 32'(CMD_SPLIT_CONTINUE));
    req = 4'b0000;
    do_finish("resumed", 4'b0100);
    chk("resumed.pending", 32'(pending), 32'd0);

    // Resume for a non-pending id and a stray done pulse are ignored
    split_resume = 1'b1; split_id = 2'd3;
    tick();
    split_resume = 1'b0;
    chk("bad_resume.pending", 32'(pending), 32'd0);
    chk("bad_resume.busy", 32'(busy), 32'd0);
    ser_done = 1'b1;
    tick();
    ser_done = 1'b0;
    chk("stray_done.ack", 32'(ack), 32'd0);

    // Reset while in WAIT_DONE
    req = 4'b0001; frame[0] = mk(CMD_WRITE, 14'h03FF, 8'h5A);
    do_grant("mid_rst", 4'b0001, 8'h5A);
    req = 4'b0000; ser_ready = 1'b1;
    tick();
    chk("mid_rst.busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst.gnt", 32'(gnt), 32'd0);
    chk("mid_rst.ack", 32'(ack), 32'd0);
    chk("mid_rst.busy", 32'(busy), 32'd0);
    chk("mid_rst.valid", 32'(ser_valid), 32'd0);
    chk("mid_rst.frame", 32'(ser_frame), 32'd0);
    req = 4'b1001;
    do_grant("post_rst", 4'b0001, 8'h5A);
    chk("post_rst.no_ack", 32'(ack), 32'd0);
    req = 4'b0000;
    do_finish("post_rst", 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "time limit");
  end

endmodule
